// File: rtl/fpu_operand_arbiter.sv
// Round-robin arbiter sharing one FP operator between two requesters.
// Optional watchdog on the operator response is enabled with the ARB_TIMEOUT_EN macro.
`timescale 1ns / 1ps

module fpu_operand_arbiter #(
  parameter int unsigned P       = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REQ_0,
  input  logic         REQ_1,
  input  logic [P-1:0] D_0,
  input  logic [P-1:0] D_1,
  output logic         MS,
  output logic [P-1:0] D_OUT,
  output logic         UNIT_START,
  input  logic         UNIT_DONE,
  input  logic [P-1:0] UNIT_RES,
  output logic [P-1:0] RES,
  output logic         ACK_0,
  output logic         ACK_1,
  output logic         BUSY,
  output logic         ERR
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e         state_q, state_d;
  logic           ms_q, ms_d;
  logic [P-1:0]   d_out_q, d_out_d;
  logic           start_q, start_d;
  logic [P-1:0]   res_q, res_d;
  logic           ack0_q, ack0_d;
  logic           ack1_q, ack1_d;
  logic           busy_q, busy_d;
  logic           last_q, last_d;
  logic           grant;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam int unsigned ExpW = (P == 64) ? 11 : (P == 16) ? 5 : 8;
  localparam logic [P-1:0] One = 1;
  // Exponent all ones plus the mantissa MSB: a run of ExpW+1 ones below the sign bit.
  localparam logic [P-1:0] QNan = ((One << (ExpW + 1)) - One) << (P - 2 - ExpW);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    d_out_d = d_out_q;
    start_d = 1'b0;
    res_d   = res_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    last_d  = last_q;
    grant   = ms_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (REQ_0 || REQ_1) begin
          grant   = (REQ_0 && REQ_1) ? ~last_q : REQ_1;
          ms_d    = grant;
          d_out_d = grant ? D_1 : D_0;
          start_d = 1'b1;
          state_d = StWait;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StWait: begin
        if (UNIT_DONE) begin
          res_d   = UNIT_RES;
          ack0_d  = ~ms_q;
          ack1_d  = ms_q;
          last_d  = ms_q;
          state_d = StResp;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          res_d   = QNan;
          ack0_d  = ~ms_q;
          ack1_d  = ms_q;
          last_d  = ms_q;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      StResp: begin
        // First RESP cycle carries the ACK; the second lets the requester drop REQ.
        if (!(ack0_q || ack1_q)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      ms_q    <= 1'b0;
      d_out_q <= '0;
      start_q <= 1'b0;
      res_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      d_out_q <= d_out_d;
      start_q <= start_d;
      res_q   <= res_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign ERR = 1'b0;
`endif

  assign MS         = ms_q;
  assign D_OUT      = d_out_q;
  assign UNIT_START = start_q;
  assign RES        = res_q;
  assign ACK_0      = ack0_q;
  assign ACK_1      = ack1_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_fpu_operand_arbiter.sv
// Scoreboard bench for fpu_operand_arbiter: directed requests, operator model, queue-based monitor.
`timescale 1ns / 1ps

module tb_fpu_operand_arbiter;

  localparam int unsigned P  = 32;
  localparam int unsigned TO = 8;
  localparam logic [31:0] KEY = 32'h40800004;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          REQ_0 = 1'b0, REQ_1 = 1'b0;
  logic [P-1:0]  D_0 = '0, D_1 = '0;
  logic          MS, UNIT_START, ACK_0, ACK_1, BUSY, ERR;
  logic [P-1:0]  D_OUT, RES;
  logic          UNIT_DONE;
  logic [P-1:0]  UNIT_RES;

  logic          op_done = 1'b0, man_done = 1'b0;
  logic [P-1:0]  op_res = '0, man_res = '0, pend = '0;
  int            op_lat = 1;
  bit            op_en = 1'b1;
  int            cd = 0;

  assign UNIT_DONE = op_done | man_done;
  assign UNIT_RES  = man_done ? man_res : op_res;

  always #5 CLK = ~CLK;

  fpu_operand_arbiter #(.P(P), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .REQ_0(REQ_0), .REQ_1(REQ_1), .D_0(D_0), .D_1(D_1),
    .MS(MS), .D_OUT(D_OUT), .UNIT_START(UNIT_START), .UNIT_DONE(UNIT_DONE),
    .UNIT_RES(UNIT_RES), .RES(RES), .ACK_0(ACK_0), .ACK_1(ACK_1), .BUSY(BUSY), .ERR(ERR)
  );

  typedef struct {
    logic        who;
    logic [31:0] d;
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t start_q[$];
  exp_t ack_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_start(input logic who, input logic [31:0] d);
    exp_t e;
    e.who = who; e.d = d; e.res = '0; e.err = 1'b0;
    start_q.push_back(e);
  endtask

  task automatic expect_txn(input logic who, input logic [31:0] d, input logic [31:0] res,
                            input logic err);
    exp_t e;
    e.who = who; e.d = d; e.res = res; e.err = err;
    start_q.push_back(e);
    ack_q.push_back(e);
  endtask

  // Operator model: result appears L cycles after the cycle UNIT_START is high.
  initial forever begin
    @(posedge CLK);
    #1;
    op_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        op_done = 1'b1;
        op_res  = pend;
      end
    end
    if (UNIT_START && op_en && RST) begin
      cd   = op_lat;
      pend = D_OUT ^ KEY;
    end
  end

  // Monitor: pops expectations whenever the DUT starts the operator or acknowledges.
  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (RST === 1'b1) begin
      if (UNIT_START) begin
        if (start_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL start_unexpected: got MS=%0d D_OUT=%h expected no start", MS, D_OUT);
        end else begin
          e = start_q.pop_front();
          chk("start_ms", MS, e.who);
          chk("start_dout", D_OUT, e.d);
        end
      end
      if (ACK_0 || ACK_1) begin
        chk("ack_onehot", ACK_0 & ACK_1, 0);
        if (ack_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL ack_unexpected: got ACK_0=%0d ACK_1=%0d expected none", ACK_0, ACK_1);
        end else begin
          e = ack_q.pop_front();
          chk("ack_id", {ACK_1, ACK_0}, e.who ? 2'b10 : 2'b01);
          chk("ack_res", RES, e.res);
          chk("ack_err", ERR, e.err);
        end
      end else if (ERR) begin
        checks++; failures++;
        $display("FAIL err_without_ack: got ERR=1 expected 0");
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ms"}, MS, 0);
    chk({tag, "_dout"}, D_OUT, 0);
    chk({tag, "_start"}, UNIT_START, 0);
    chk({tag, "_res"}, RES, 0);
    chk({tag, "_acks"}, {ACK_1, ACK_0}, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_err"}, ERR, 0);
  endtask

  // Requesters: drop REQ on ACK, re-raise one cycle later while more transactions remain.
  task automatic serve(input int n0, input int n1, input int budget);
    int left0 = n0, left1 = n1, cyc = 0;
    bit re0 = 0, re1 = 0;
    REQ_0 = (n0 > 0);
    REQ_1 = (n1 > 0);
    while ((left0 > 0 || left1 > 0) && cyc < budget) begin
      @(negedge CLK);
      cyc++;
      if (re0) begin REQ_0 = 1'b1; re0 = 0; end
      if (re1) begin REQ_1 = 1'b1; re1 = 0; end
      if (ACK_0) begin left0--; REQ_0 = 1'b0; re0 = (left0 > 0); end
      if (ACK_1) begin left1--; REQ_1 = 1'b0; re1 = (left1 > 0); end
    end
    REQ_0 = 1'b0;
    REQ_1 = 1'b0;
    chk("serve_complete", (left0 == 0 && left1 == 0), 1);
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2;
    check_reset_outputs("reset");
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Single request, L=3
    op_lat = 3;
    D_0 = 32'h00000004;
    REQ_0 = 1'b1;
    expect_txn(1'b0, 32'h00000004, 32'h40800000, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge CLK);
      if (c == 1) begin chk("single_start_c1", UNIT_START, 1); chk("single_busy_c1", BUSY, 1); end
      if (c == 2) chk("single_start_drop", UNIT_START, 0);
      if (c == 4) chk("single_no_ack_c4", ACK_0, 0);
      if (c == 5) begin chk("single_ack_c5", ACK_0, 1); REQ_0 = 1'b0; end
      if (c == 6) begin chk("single_ack_low", ACK_0, 0); chk("single_busy_resp", BUSY, 1); end
      if (c == 7) chk("single_idle", BUSY, 0);
    end

    // Spurious UNIT_DONE in IDLE
    @(posedge CLK); #1;
    man_res = 32'hDEADBEEF;
    man_done = 1'b1;
    @(posedge CLK); #1;
    man_done = 1'b0;
    repeat (2) @(negedge CLK);
    chk("spurious_res", RES, 32'h40800000);
    chk("spurious_busy", BUSY, 0);

    // Reset, then tie: requester 0 first
    RST = 1'b0;
    #2;
    check_reset_outputs("reset2");
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    op_lat = 2;
    D_0 = 32'h00000004;
    D_1 = 32'h80000001;
    expect_txn(1'b0, 32'h00000004, 32'h40800000, 1'b0);
    expect_txn(1'b1, 32'h80000001, 32'hC0800005, 1'b0);
    serve(1, 1, 60);

    // Round-robin fairness over six transactions
    op_lat = 1;
    D_0 = 32'h00000010;
    D_1 = 32'h00000020;
    for (int i = 0; i < 3; i++) begin
      expect_txn(1'b0, 32'h00000010, 32'h40800014, 1'b0);
      expect_txn(1'b1, 32'h00000020, 32'h40800024, 1'b0);
    end
    serve(3, 3, 200);
    chk("idle_ms_hold", MS, 1);
    chk("idle_dout_hold", D_OUT, 32'h00000020);
    chk("fair_queue_empty", ack_q.size(), 0);

    // Reset mid-WAIT, then a late UNIT_DONE
    op_en = 1'b0;
    D_1 = 32'h00000055;
    REQ_1 = 1'b1;
    expect_start(1'b1, 32'h00000055);
    @(negedge CLK);
    chk("midwait_start", UNIT_START, 1);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    REQ_1 = 1'b0;
    #2;
    check_reset_outputs("midwait");
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    man_res = 32'h12345678;
    man_done = 1'b1;
    @(posedge CLK); #1;
    man_done = 1'b0;
    repeat (2) @(negedge CLK);
    chk("midwait_late_res", RES, 0);
    chk("midwait_late_busy", BUSY, 0);

    // Operator never answers
    D_1 = 32'h00000099;
    REQ_1 = 1'b1;
`ifdef ARB_TIMEOUT_EN
    expect_txn(1'b1, 32'h00000099, 32'h7FC00000, 1'b1);
    for (int c = 1; c <= 13; c++) begin
      @(negedge CLK);
      if (c == 9) chk("timeout_no_ack_c9", ACK_1, 0);
      if (c == 10) begin
        chk("timeout_ack_c10", ACK_1, 1);
        chk("timeout_err_c10", ERR, 1);
        REQ_1 = 1'b0;
      end
      if (c == 13) chk("timeout_idle", BUSY, 0);
    end
`else
    expect_start(1'b1, 32'h00000099);
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      chk("noto_err", ERR, 0);
    end
    chk("noto_busy", BUSY, 1);
    REQ_1 = 1'b0;
    RST = 1'b0;
    #2;
    chk("noto_reset_busy", BUSY, 0);
    @(negedge CLK);
    RST = 1'b1;
    ack_q.delete();
`endif
    repeat (3) @(negedge CLK);
    chk("final_start_queue", start_q.size(), 0);
    chk("final_ack_queue", ack_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
